// File: rtl/toy_bus_pkg.sv
// Shared ToyBus definitions: ack payload, width constants, default target IDs
// and the target decode used by the ack decode node.
package toy_bus_pkg;

  localparam int DATA_W  = 32;
  localparam int ID_W    = 4;
  localparam int OUT_NUM = 4;

  localparam logic [ID_W-1:0] TGT_ID_0_DEF = 4'd0;
  localparam logic [ID_W-1:0] TGT_ID_1_DEF = 4'd1;
  localparam logic [ID_W-1:0] TGT_ID_2_DEF = 4'd2;
  localparam logic [ID_W-1:0] TGT_ID_3_DEF = 4'd3;

  typedef struct packed {
    logic              opcode;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   src_id;
    logic [ID_W-1:0]   tgt_id;
  } ack_t;

  typedef logic [OUT_NUM-1:0] sel_t;

  typedef struct packed {
    sel_t sel;
    ack_t pkt;
  } entry_t;

  // Lowest matching index wins, so the result is always one-hot or zero.
  function automatic sel_t dec_tgt(input logic [ID_W-1:0] tgt,
                                   input logic [ID_W-1:0] id0,
                                   input logic [ID_W-1:0] id1,
                                   input logic [ID_W-1:0] id2,
                                   input logic [ID_W-1:0] id3);
    sel_t sel;
    sel = '0;
    if (tgt == id0)      sel = 4'b0001;
    else if (tgt == id1) sel = 4'b0010;
    else if (tgt == id2) sel = 4'b0100;
    else if (tgt == id3) sel = 4'b1000;
    return sel;
  endfunction

endpackage

// File: rtl/toy_bus_skid_buf.sv
// Generic 2-entry skid buffer: push_rdy comes from registered state only, so no
// combinational path from the consumer's ready back to the producer.
//   state | meaning
//   EMPTY | main and skid empty
//   ONE   | main holds the head entry, skid empty
//   FULL  | main holds the head, skid holds the next entry, push_rdy low
module toy_bus_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         push_rdy,
  input  logic         pop,
  output logic         main_vld,
  output logic [W-1:0] main_data
);

  logic         skid_vld;
  logic [W-1:0] skid_data;

  assign push_rdy = ~skid_vld;

  // pop is only asserted by the owner while main_vld is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      case ({skid_vld, main_vld})
        2'b00: begin
          if (push) begin
            main_vld  <= 1'b1;
            main_data <= push_data;
          end
        end
        2'b01: begin
          if (push && pop) begin
            main_data <= push_data;
          end else if (push) begin
            skid_vld  <= 1'b1;
            skid_data <= push_data;
          end else if (pop) begin
            main_vld <= 1'b0;
          end
        end
        2'b11: begin
          if (pop) begin
            main_data <= skid_data;
            skid_vld  <= 1'b0;
          end
        end
        default: begin
          main_vld <= 1'b0;
          skid_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/toy_bus_dec_node_ack_slice.sv
// Registered 1-to-4 decode node for the ToyBusAck channel; unmapped packets are
// dropped and flagged. TOY_BUS_DEC_ERR_CNT_EN adds a saturating drop counter.
module toy_bus_dec_node_ack_slice
  import toy_bus_pkg::*;
#(
  parameter logic [ID_W-1:0] TGT_ID_0 = TGT_ID_0_DEF,
  parameter logic [ID_W-1:0] TGT_ID_1 = TGT_ID_1_DEF,
  parameter logic [ID_W-1:0] TGT_ID_2 = TGT_ID_2_DEF,
  parameter logic [ID_W-1:0] TGT_ID_3 = TGT_ID_3_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic              in_opcode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ID_W-1:0]   in_src_id,
  input  logic [ID_W-1:0]   in_tgt_id,
  output logic              out0_vld,
  input  logic              out0_rdy,
  output logic              out0_opcode,
  output logic [DATA_W-1:0] out0_data,
  output logic [ID_W-1:0]   out0_src_id,
  output logic [ID_W-1:0]   out0_tgt_id,
  output logic              out1_vld,
  input  logic              out1_rdy,
  output logic              out1_opcode,
  output logic [DATA_W-1:0] out1_data,
  output logic [ID_W-1:0]   out1_src_id,
  output logic [ID_W-1:0]   out1_tgt_id,
  output logic              out2_vld,
  input  logic              out2_rdy,
  output logic              out2_opcode,
  output logic [DATA_W-1:0] out2_data,
  output logic [ID_W-1:0]   out2_src_id,
  output logic [ID_W-1:0]   out2_tgt_id,
  output logic              out3_vld,
  input  logic              out3_rdy,
  output logic              out3_opcode,
  output logic [DATA_W-1:0] out3_data,
  output logic [ID_W-1:0]   out3_src_id,
  output logic [ID_W-1:0]   out3_tgt_id,
`ifdef TOY_BUS_DEC_ERR_CNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              err_unmapped
);

  ack_t                    in_pkt;
  sel_t                    in_sel;
  entry_t                  push_entry;
  entry_t                  main_entry;
  logic [$bits(entry_t)-1:0] main_bits;
  logic                    main_vld;
  logic                    buf_rdy;
  logic                    in_fire;
  logic                    drop;
  logic                    push;
  logic                    pop;
  sel_t                    out_rdy_v;
  sel_t                    out_vld_v;

  assign in_pkt.opcode = in_opcode;
  assign in_pkt.data   = in_data;
  assign in_pkt.src_id = in_src_id;
  assign in_pkt.tgt_id = in_tgt_id;

  assign in_sel = dec_tgt(in_tgt_id, TGT_ID_0, TGT_ID_1, TGT_ID_2, TGT_ID_3);

  assign push_entry.sel = in_sel;
  assign push_entry.pkt = in_pkt;

  assign in_rdy  = buf_rdy;
  assign in_fire = in_vld & buf_rdy;
  assign push    = in_fire & (|in_sel);
  assign drop    = in_fire & ~(|in_sel);

  assign out_rdy_v = {out3_rdy, out2_rdy, out1_rdy, out0_rdy};
  assign pop       = main_vld & (|(main_entry.sel & out_rdy_v));

  toy_bus_skid_buf #(
    .W($bits(entry_t))
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .push_rdy (buf_rdy),
    .pop      (pop),
    .main_vld (main_vld),
    .main_data(main_bits)
  );

  assign main_entry = main_bits;
  assign out_vld_v  = main_vld ? main_entry.sel : '0;

  // Every output carries the head payload; only its vld qualifies it.
  assign out0_vld    = out_vld_v[0];
  assign out0_opcode = main_entry.pkt.opcode;
  assign out0_data   = main_entry.pkt.data;
  assign out0_src_id = main_entry.pkt.src_id;
  assign out0_tgt_id = main_entry.pkt.tgt_id;
  assign out1_vld    = out_vld_v[1];
  assign out1_opcode = main_entry.pkt.opcode;
  assign out1_data   = main_entry.pkt.data;
  assign out1_src_id = main_entry.pkt.src_id;
  assign out1_tgt_id = main_entry.pkt.tgt_id;
  assign out2_vld    = out_vld_v[2];
  assign out2_opcode = main_entry.pkt.opcode;
  assign out2_data   = main_entry.pkt.data;
  assign out2_src_id = main_entry.pkt.src_id;
  assign out2_tgt_id = main_entry.pkt.tgt_id;
  assign out3_vld    = out_vld_v[3];
  assign out3_opcode = main_entry.pkt.opcode;
  assign out3_data   = main_entry.pkt.data;
  assign out3_src_id = main_entry.pkt.src_id;
  assign out3_tgt_id = main_entry.pkt.tgt_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_unmapped <= 1'b0;
    else        err_unmapped <= drop;
  end

`ifdef TOY_BUS_DEC_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err_cnt <= 8'd0;
    else if (drop && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_toy_bus_dec_node_ack_slice.sv
// Scoreboard bench for the ToyBusAck decode node: accepted packets are queued
// in acceptance order and checked against the outputs as they are presented.
module tb_toy_bus_dec_node_ack_slice;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic        in_opcode = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_src_id = '0;
  logic [3:0]  in_tgt_id = '0;
  logic [3:0]  out_rdy = 4'hF;
  logic        o_vld [4];
  logic        o_op [4];
  logic [31:0] o_data [4];
  logic [3:0]  o_src [4];
  logic [3:0]  o_tgt [4];
  logic        err_unmapped;
`ifdef TOY_BUS_DEC_ERR_CNT_EN
  logic [7:0]  err_cnt;
  logic [7:0]  d_err_cnt;
  int          err_cnt_exp = 0;
`endif

  logic        d_in_vld = 1'b0;
  logic        d_in_rdy;
  logic [3:0]  d_in_tgt_id = '0;
  logic [3:0]  d_vld;
  logic        d_err;
  logic        d_op [4];
  logic [31:0] d_data [4];
  logic [3:0]  d_src [4];
  logic [3:0]  d_tgt [4];

  int total = 0;
  int bad = 0;

  typedef struct {
    int          k;
    logic        op;
    logic [31:0] data;
    logic [3:0]  src;
    logic [3:0]  tgt;
  } exp_t;

  exp_t q[$];
  logic exp_rdy = 1'b1;
  logic err_due = 1'b0;
  int   ids[4] = '{0, 1, 2, 3};

  always #5 clk = ~clk;

  toy_bus_dec_node_ack_slice dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_opcode(in_opcode), .in_data(in_data),
    .in_src_id(in_src_id), .in_tgt_id(in_tgt_id),
    .out0_vld(o_vld[0]), .out0_rdy(out_rdy[0]), .out0_opcode(o_op[0]), .out0_data(o_data[0]),
    .out0_src_id(o_src[0]), .out0_tgt_id(o_tgt[0]),
    .out1_vld(o_vld[1]), .out1_rdy(out_rdy[1]), .out1_opcode(o_op[1]), .out1_data(o_data[1]),
    .out1_src_id(o_src[1]), .out1_tgt_id(o_tgt[1]),
    .out2_vld(o_vld[2]), .out2_rdy(out_rdy[2]), .out2_opcode(o_op[2]), .out2_data(o_data[2]),
    .out2_src_id(o_src[2]), .out2_tgt_id(o_tgt[2]),
    .out3_vld(o_vld[3]), .out3_rdy(out_rdy[3]), .out3_opcode(o_op[3]), .out3_data(o_data[3]),
    .out3_src_id(o_src[3]), .out3_tgt_id(o_tgt[3]),
`ifdef TOY_BUS_DEC_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .err_unmapped(err_unmapped)
  );

  toy_bus_dec_node_ack_slice #(
    .TGT_ID_1(4'd5), .TGT_ID_3(4'd5)
  ) dut_dup (
    .clk(clk), .rst_n(rst_n),
    .in_vld(d_in_vld), .in_rdy(d_in_rdy), .in_opcode(1'b0), .in_data(32'h0000_1234),
    .in_src_id(4'd7), .in_tgt_id(d_in_tgt_id),
    .out0_vld(d_vld[0]), .out0_rdy(1'b1), .out0_opcode(d_op[0]), .out0_data(d_data[0]),
    .out0_src_id(d_src[0]), .out0_tgt_id(d_tgt[0]),
    .out1_vld(d_vld[1]), .out1_rdy(1'b1), .out1_opcode(d_op[1]), .out1_data(d_data[1]),
    .out1_src_id(d_src[1]), .out1_tgt_id(d_tgt[1]),
    .out2_vld(d_vld[2]), .out2_rdy(1'b1), .out2_opcode(d_op[2]), .out2_data(d_data[2]),
    .out2_src_id(d_src[2]), .out2_tgt_id(d_tgt[2]),
    .out3_vld(d_vld[3]), .out3_rdy(1'b1), .out3_opcode(d_op[3]), .out3_data(d_data[3]),
    .out3_src_id(d_src[3]), .out3_tgt_id(d_tgt[3]),
`ifdef TOY_BUS_DEC_ERR_CNT_EN
    .err_cnt(d_err_cnt),
`endif
    .err_unmapped(d_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int map_tgt(input logic [3:0] t);
    for (int i = 0; i < 4; i++)
      if (int'(t) == ids[i]) return i;
    return -1;
  endfunction

  // Acceptance side of the model: records what the node takes at each edge.
  always @(posedge clk) begin
    int k;
    err_due = 1'b0;
    if (rst_n && in_vld && exp_rdy) begin
      k = map_tgt(in_tgt_id);
      if (k < 0) begin
        err_due = 1'b1;
`ifdef TOY_BUS_DEC_ERR_CNT_EN
        if (err_cnt_exp < 255) err_cnt_exp++;
`endif
      end else begin
        q.push_back('{k: k, op: in_opcode, data: in_data, src: in_src_id, tgt: in_tgt_id});
      end
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    err_due = 1'b0;
`ifdef TOY_BUS_DEC_ERR_CNT_EN
    err_cnt_exp = 0;
`endif
  end

  // Monitor: head of the queue must be what the node presents right now.
  always @(negedge clk) begin
    int n;
    logic [3:0] ev;
    logic [3:0] av;
    n  = q.size();
    ev = (n > 0) ? (4'b0001 << q[0].k) : 4'b0000;
    av = {o_vld[3], o_vld[2], o_vld[1], o_vld[0]};
    chk("out_vld", 64'(av), 64'(ev));
    chk("in_rdy", 64'(in_rdy), 64'(n < 2));
    chk("err_unmapped", 64'(err_unmapped), 64'(err_due));
`ifdef TOY_BUS_DEC_ERR_CNT_EN
    chk("err_cnt", 64'(err_cnt), 64'(err_cnt_exp));
`endif
    if (n > 0) begin
      chk("payload", 64'({o_op[q[0].k], o_data[q[0].k], o_src[q[0].k], o_tgt[q[0].k]}),
          64'({q[0].op, q[0].data, q[0].src, q[0].tgt}));
      if (out_rdy[q[0].k]) void'(q.pop_front());
    end
    exp_rdy = (n < 2);
  end

  task automatic send(input logic [3:0] tgt, input logic [31:0] data,
                      input logic [3:0] src, input logic op);
    int w;
    in_vld = 1'b1; in_tgt_id = tgt; in_data = data; in_src_id = src; in_opcode = op;
    for (w = 0; w < 50; w++) begin
      @(posedge clk);
      if (exp_rdy) break;
    end
    #1 in_vld = 1'b0;
    if (w == 50) begin
      total++; bad++;
      $display("FAIL send_timeout actual=stalled required=accepted tgt=%0d", tgt);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dup_send(input logic [3:0] tgt, input logic [3:0] ev, input logic eerr);
    @(posedge clk); #1;
    d_in_vld = 1'b1; d_in_tgt_id = tgt;
    @(posedge clk); #1;
    d_in_vld = 1'b0;
    @(negedge clk);
    chk("dup_vld", 64'(d_vld), 64'(ev));
    chk("dup_err", 64'(d_err), 64'(eerr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++)
      send(4'(i % 4), 32'h1000_0000 + 32'(i), 4'(i), 1'(i));
    idle(3);

    out_rdy = 4'b1011;
    fork
      for (int i = 0; i < 6; i++) send(4'd2, 32'hDEADBEEF, 4'(i), 1'b1);
      begin idle(6); out_rdy = 4'hF; end
    join
    idle(4);

    out_rdy = 4'b1101;
    send(4'd1, 32'hAAAA_0001, 4'd1, 1'b0);
    send(4'd3, 32'hBBBB_0003, 4'd3, 1'b1);
    idle(4);
    out_rdy = 4'hF;
    idle(4);

    send(4'd9, 32'h0000_0009, 4'd2, 1'b0);
    idle(2);
    send(4'd9, 32'h0000_0019, 4'd2, 1'b0);
    send(4'd0, 32'h0000_0020, 4'd2, 1'b1);
    send(4'd15, 32'h0000_002F, 4'd2, 1'b0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 5));
      in_vld    = 1'($urandom_range(0, 3) != 0);
      in_tgt_id = (r > 3) ? 4'(r * 3) : 4'(r);
      in_data   = $urandom;
      in_src_id = 4'($urandom);
      in_opcode = 1'($urandom);
      out_rdy   = 4'($urandom) | 4'($urandom);
      idle(1);
    end
    in_vld = 1'b0; out_rdy = 4'hF;
    idle(4);

`ifdef TOY_BUS_DEC_ERR_CNT_EN
    in_vld = 1'b1; in_tgt_id = 4'd9;
    idle(300);
    in_vld = 1'b0;
    idle(3);
`endif

    out_rdy = 4'h0;
    send(4'd0, 32'h5555_0000, 4'd1, 1'b0);
    send(4'd1, 32'h5555_0001, 4'd1, 1'b0);
    in_vld = 1'b1; in_tgt_id = 4'd2;
    idle(2);
    rst_n = 1'b0;
    in_vld = 1'b0;
    idle(3);
    @(posedge clk); #1 rst_n = 1'b1;
    out_rdy = 4'hF;
    idle(2);
    send(4'd3, 32'h6666_0003, 4'd4, 1'b1);
    send(4'd2, 32'h6666_0002, 4'd4, 1'b0);
    idle(4);

    dup_send(4'd5, 4'b0010, 1'b0);
    dup_send(4'd3, 4'b0000, 1'b1);
    dup_send(4'd2, 4'b0100, 1'b0);
    dup_send(4'd1, 4'b0000, 1'b1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
